ahb2_slv_mem: RTL and testbench
===============================

Name: ahb2_slv_mem

Overview:
Parametrised AHB2 slave memory: next generation of the team's AHB2 slave endpoint, generalised in data width, depth and wait states. Adds byte-lane writes, configurable wait states, and the two-cycle ERROR response. Sits behind the AHB2 decoder/mux on the slave side (hsel/hreadyi in, hreadyo out) and serves as on-chip SRAM model and bring-up target.

Parameters:
DATA_W, 32, data bus width; 32 or 64 only
ADDR_W, 32, haddr width
DEPTH, 1024, memory depth in DATA_W words; power of two
BASE_ADDR, 0, byte base address; aligned to DEPTH*DATA_W/8
WAIT_CYCLES, 0, wait states inserted per OKAY transfer; 0..15
ERR_UNALIGNED, 1, 1 = unaligned transfer answers ERROR; 0 = low address bits are masked to the size boundary

Ports:
hclk  in  1  clock
hreset  in  1  asynchronous, active-high reset
hsel  in  1  slave select
haddr  in  ADDR_W  byte address
htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
hwrite  in  1  1 = write
hsize  in  3  transfer size
hburst  in  3  burst type; ignored, because the address is supplied per beat
hprot  in  4  ignored
hwdata  in  DATA_W  write data (data phase)
hreadyi  in  1  bus HREADY; previous transfer done
hrdata  out  DATA_W  read data
hreadyo  out  1  slave ready
hresp  out  2  OKAY/ERROR

Behaviour:
- Reset (async assert, sync deassert at the bench): state=IDLE, hreadyo=1, hresp=OKAY, hrdata=0, wait counter=0. Memory array is not reset.
- Address phase accepted when hsel & hreadyi & htrans[1] (NONSEQ/SEQ).
  - Registers addr, hwrite, hsize and the byte enables.
  - Then moves to DATA or ERR1.
- IDLE/BUSY or hsel=0 with hreadyi=1: the next cycle is a zero-wait OKAY (state IDLE).
- Error checks, all evaluated in the address phase:
  - (1<<hsize) > DATA_W/8
  - haddr outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8)
  - haddr not aligned to the size, when ERR_UNALIGNED=1
- States:
  - IDLE: hreadyo=1, hresp=OKAY.
  - DATA: counter loads WAIT_CYCLES. While counter!=0: hreadyo=0, hresp=OKAY, decrement. When counter==0: hreadyo=1, hresp=OKAY. Read: hrdata=mem[word]. Write: hwdata bytes with enable set are written into mem[word] at this edge. A new address phase may be accepted on the same edge (pipelined).
  - ERR1: hreadyo=0, hresp=ERROR, no memory access. Goes to ERR2.
  - ERR2: hreadyo=1, hresp=ERROR. Accepts a new address phase like the end of DATA; otherwise goes to IDLE.
- Latency: with WAIT_CYCLES=0, reads and writes complete one cycle after the address phase. Each beat adds WAIT_CYCLES.
- hrdata = 0 whenever not in a completing read cycle.
- Byte enables: little-endian. The lane set is 2^hsize bytes starting at addr[log2(DATA_W/8)-1:0]. With ERR_UNALIGNED=0 that offset is first masked down to the size boundary.
- Write followed by a read of the same word: the write commits on its final data-phase edge, so the read returns the new data with no stall.
- Reset asserted mid-transfer: the transfer is abandoned and outputs take their reset values immediately. A partial write never commits.
- Word index = (addr-BASE_ADDR) >> log2(DATA_W/8), truncated to log2(DEPTH) bits.

Decomposition:
- Package ahb2_pkg:
  - HTRANS_*, HRESP_*, HBURST_*, HSIZE_* constants
  - state enum (IDLE, DATA, ERR1, ERR2)
  - function size_bytes(hsize)
- Sub-module ahb2_byte_strobe_gen, combinational: (hsize, addr low bits, DATA_W) -> DATA_W/8 byte enable plus an unaligned flag.

Test Plan:
- DATA_W=32, WAIT_CYCLES=0: write 0xDEADBEEF @0x10 word, then read @0x10 back-to-back -> hreadyo stays 1; hrdata=0xDEADBEEF in the cycle after the read address phase.
- Byte writes 0x11 @0x21, 0x22 @0x22 over prior word 0 -> word read @0x20 returns 0x00221100.
- WAIT_CYCLES=3, INCR4 read @0x40..0x4C -> each beat shows 3 cycles of hreadyo=0 then 1. Burst takes 16 data cycles and returns the 4 preloaded words in order.
- Read @BASE+DEPTH*4 -> ERR1 (hreadyo=0, hresp=ERROR) then ERR2 (hreadyo=1, hresp=ERROR); a NONSEQ read in ERR2 completes OKAY the next cycle.
- Word write @0x02, ERR_UNALIGNED=1 -> ERROR pair and memory unchanged. Same with ERR_UNALIGNED=0 -> writes the word @0x00.
- DATA_W=64, WAIT_CYCLES=2: assert hreset during the second wait cycle of a write -> hreadyo=1, hresp=OKAY, hrdata=0 immediately; a later read shows the old data.

Source files
------------

// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings, the slave FSM state type and the transfer-size helper
// used by the slave memory and its byte-strobe generator.
package ahb2_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_e;

  // Bytes moved by one beat of the given hsize (up to 128).
  function automatic logic [7:0] size_bytes(input logic [2:0] hsize);
    return 8'd1 << hsize;
  endfunction

endpackage

// File: rtl/ahb2_byte_strobe_gen.sv
// Little-endian byte-lane enables for one AHB beat, plus a flag telling whether
// the address is off its natural size boundary.
module ahb2_byte_strobe_gen
  import ahb2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                  hsize,
  input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
  output logic [DATA_W/8-1:0]         be,
  output logic                        unaligned
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  logic [7:0]       nbytes;
  logic [7:0]       lo_b;
  logic [7:0]       hi_b;
  logic [OFF_W-1:0] size_mask;

  // The lane window always starts at the size-aligned offset; an unaligned
  // beat is either rejected upstream or intentionally masked down.
  always_comb begin
    nbytes    = size_bytes(hsize);
    size_mask = OFF_W'(nbytes - 8'd1);
    unaligned = (addr_lo & size_mask) != '0;
    lo_b      = 8'(addr_lo & ~size_mask);
    hi_b      = lo_b + nbytes;
  end

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign be[gi] = (8'(gi) >= lo_b) && (8'(gi) < hi_b);
    end
  endgenerate

endmodule

// File: rtl/ahb2_slv_mem.sv
// AHB2 slave SRAM with byte-lane writes, configurable wait states and the
// two-cycle ERROR response; read port is registered with write forwarding.
module ahb2_slv_mem
  import ahb2_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 32,
  parameter int                DEPTH         = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int                WAIT_CYCLES   = 0,
  parameter bit                ERR_UNALIGNED = 1'b1
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hreadyi,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyo,
  output logic [1:0]        hresp
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SPAN  = DEPTH * BYTES;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  word_q, word_d;
  logic [BYTES-1:0]  be_q, be_d;
  logic              write_q, write_d;

  logic [ADDR_W:0]   off_full;
  logic [IDX_W-1:0]  word_in;
  logic [IDX_W-1:0]  rd_idx;
  logic [BYTES-1:0]  be_in;
  logic              unaligned;
  logic              accept;
  logic              can_accept;
  logic              xfer_err;
  logic              data_last;
  logic              we;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_merged;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [BYTES-1:0]  fwd_be_q, fwd_be_d;
  logic              fwd_hit_q, fwd_hit_d;

  // Burst type, protection and the BUSY/IDLE distinction carry no meaning here.
  logic unused_in;
  assign unused_in = ^{htrans[0], hburst, hprot};

  ahb2_byte_strobe_gen #(.DATA_W(DATA_W)) u_strobe (
    .hsize     (hsize),
    .addr_lo   (haddr[OFF_W-1:0]),
    .be        (be_in),
    .unaligned (unaligned)
  );

  always_comb begin
    off_full   = {1'b0, haddr} - {1'b0, BASE_ADDR};
    word_in    = off_full[OFF_W +: IDX_W];
    accept     = hsel && hreadyi && htrans[1];
    // A borrow from the subtraction lands above SPAN, so one compare covers both ends.
    xfer_err   = (size_bytes(hsize) > 8'(BYTES)) ||
                 (off_full >= (ADDR_W+1)'(SPAN)) ||
                 (ERR_UNALIGNED && unaligned);
    data_last  = (state_q == DATA) && (cnt_q == 4'd0);
    we         = data_last && write_q;
    can_accept = (state_q == IDLE) || (state_q == ERR2) || data_last;

    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    be_d    = be_q;
    write_d = write_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      DATA:    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
               else               state_d = IDLE;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (can_accept && accept) begin
      state_d = xfer_err ? ERR1 : DATA;
      cnt_d   = xfer_err ? 4'd0 : 4'(WAIT_CYCLES);
      word_d  = word_in;
      be_d    = be_in;
      write_d = hwrite;
    end

    // A write committing on the same edge the read port samples must be
    // merged in, otherwise a back-to-back read would see stale bytes.
    rd_idx     = (can_accept && accept) ? word_in : word_q;
    fwd_hit_d  = we && (rd_idx == word_q);
    fwd_be_d   = be_q;
    fwd_data_d = hwdata;

    hreadyo = !(((state_q == DATA) && (cnt_q != 4'd0)) || (state_q == ERR1));
    hresp   = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    hrdata  = (data_last && !write_q) ? rd_merged : '0;
  end

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_merge
      assign rd_merged[gi*8 +: 8] = (fwd_hit_q && fwd_be_q[gi]) ? fwd_data_q[gi*8 +: 8]
                                                                 : rd_q[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      be_q    <= be_d;
      write_q <= write_d;
    end
  end

  // Storage and its read register are never reset.
  always_ff @(posedge hclk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) mem[word_q][b*8 +: 8] <= hwdata[b*8 +: 8];
      end
    end
    rd_q       <= mem[rd_idx];
    fwd_hit_q  <= fwd_hit_d;
    fwd_be_q   <= fwd_be_d;
    fwd_data_q <= fwd_data_d;
  end

endmodule

// File: tb/tb_ahb2_slv_mem.sv
// Directed bench for ahb2_slv_mem: three instances (32-bit zero-wait, 32-bit
// three-wait with masking, 64-bit two-wait at a nonzero base) on one bus.
module tb_ahb2_slv_mem;
  import ahb2_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  int          sel;
  logic        hsel_bus;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [63:0] hwdata;
  logic        hreadyi;

  logic        hsel_a, hsel_b, hsel_c;
  logic [31:0] rdata_a, rdata_b;
  logic [63:0] rdata_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic [1:0]  resp_a, resp_b, resp_c;
  logic        cur_rdy;
  logic [1:0]  cur_resp;
  logic [63:0] cur_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 hclk = ~hclk;

  assign hsel_a    = hsel_bus && (sel == 0);
  assign hsel_b    = hsel_bus && (sel == 1);
  assign hsel_c    = hsel_bus && (sel == 2);
  assign cur_rdy   = (sel == 0) ? rdy_a : (sel == 1) ? rdy_b : rdy_c;
  assign cur_resp  = (sel == 0) ? resp_a : (sel == 1) ? resp_b : resp_c;
  assign cur_rdata = (sel == 0) ? {32'h0, rdata_a} : (sel == 1) ? {32'h0, rdata_b} : rdata_c;
  assign hreadyi   = cur_rdy;

  ahb2_slv_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .BASE_ADDR(32'h0),
                 .WAIT_CYCLES(0), .ERR_UNALIGNED(1'b1)) u_a (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hwdata(hwdata[31:0]), .hreadyi(hreadyi), .hrdata(rdata_a), .hreadyo(rdy_a),
    .hresp(resp_a));

  ahb2_slv_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .BASE_ADDR(32'h0),
                 .WAIT_CYCLES(3), .ERR_UNALIGNED(1'b0)) u_b (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hwdata(hwdata[31:0]), .hreadyi(hreadyi), .hrdata(rdata_b), .hreadyo(rdy_b),
    .hresp(resp_b));

  ahb2_slv_mem #(.DATA_W(64), .ADDR_W(32), .DEPTH(256), .BASE_ADDR(32'h0000_8000),
                 .WAIT_CYCLES(2), .ERR_UNALIGNED(1'b1)) u_c (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_c), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hwdata(hwdata), .hreadyi(hreadyi), .hrdata(rdata_c), .hreadyo(rdy_c),
    .hresp(resp_c));

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_addr(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                            input logic [1:0] tr);
    hsel_bus = 1'b1;
    htrans   = tr;
    hwrite   = wr;
    hsize    = sz;
    haddr    = a;
  endtask

  task automatic drive_idle();
    hsel_bus = 1'b0;
    htrans   = HTRANS_IDLE;
    hwrite   = 1'b0;
  endtask

  // One isolated transfer on the selected slave; reports data, wait count and response.
  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [63:0] wd, output logic [63:0] rd, output int waits,
                      output logic [1:0] resp);
    drive_addr(wr, sz, a, HTRANS_NONSEQ);
    tick();
    hwdata = wd;
    drive_idle();
    waits = 0;
    @(negedge hclk);
    while (!cur_rdy && waits < 50) begin
      waits++;
      tick();
      @(negedge hclk);
    end
    rd   = cur_rdata;
    resp = cur_resp;
    $display("xfer slave=%0d wr=%0b size=%0d addr=%h wdata=%h rdata=%h resp=%0d waits=%0d",
             sel, wr, sz, a, wd, rd, resp, waits);
    tick();
  endtask

  task automatic test_reset();
    hreset = 1'b0;
    sel = 0; hsel_bus = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_WORD; hburst = HBURST_SINGLE; hprot = 4'h0; hwdata = '0;
    #1 hreset = 1'b1;
    #2;
    n_cmp++; if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin n_bad++;
      $display("FAIL reset_ready: got %b expected 111", {rdy_a, rdy_b, rdy_c}); end
    n_cmp++; if ({resp_a, resp_b, resp_c} !== 6'b0) begin n_bad++;
      $display("FAIL reset_resp: got %b expected 000000", {resp_a, resp_b, resp_c}); end
    n_cmp++; if ({rdata_a, rdata_b, rdata_c} !== 128'h0) begin n_bad++;
      $display("FAIL reset_rdata: got %h expected 0", {rdata_a, rdata_b, rdata_c}); end
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
    n_cmp++; if ({rdy_a, rdy_b, rdy_c, resp_a, resp_b, resp_c} !== 9'b111_000000) begin n_bad++;
      $display("FAIL post_reset_idle: got %b expected 111000000",
               {rdy_a, rdy_b, rdy_c, resp_a, resp_b, resp_c}); end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    tick();
    drive_addr(1'b1, HSIZE_WORD, 32'h10, HTRANS_NONSEQ);
    @(negedge hclk);
    n_cmp++; if (rdy_a !== 1'b1) begin n_bad++;
      $display("FAIL b2b_addr_ready: got %b expected 1", rdy_a); end
    tick();
    hwdata = 64'hDEADBEEF;
    drive_addr(1'b0, HSIZE_WORD, 32'h10, HTRANS_NONSEQ);
    @(negedge hclk);
    n_cmp++; if (rdy_a !== 1'b1) begin n_bad++;
      $display("FAIL b2b_wr_ready: got %b expected 1", rdy_a); end
    n_cmp++; if (rdata_a !== 32'h0) begin n_bad++;
      $display("FAIL b2b_wr_rdata: got %h expected 00000000", rdata_a); end
    tick();
    drive_idle();
    @(negedge hclk);
    $display("b2b read addr=00000010 rdata=%h ready=%b resp=%0d", rdata_a, rdy_a, resp_a);
    n_cmp++; if (rdy_a !== 1'b1) begin n_bad++;
      $display("FAIL b2b_rd_ready: got %b expected 1", rdy_a); end
    n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_bad++;
      $display("FAIL b2b_rd_data: got %h expected deadbeef", rdata_a); end
    tick();
    @(negedge hclk);
    n_cmp++; if (rdata_a !== 32'h0) begin n_bad++;
      $display("FAIL b2b_rdata_idle: got %h expected 00000000", rdata_a); end
  endtask

  task automatic test_byte_lanes();
    logic [63:0] rd;
    int          waits;
    logic [1:0]  resp;
    sel = 0;
    tick();
    drive_addr(1'b1, HSIZE_WORD, 32'h20, HTRANS_NONSEQ);
    tick();
    hwdata = 64'h0;
    drive_addr(1'b1, HSIZE_BYTE, 32'h21, HTRANS_NONSEQ);
    tick();
    hwdata = 64'h0000_1100;
    drive_addr(1'b1, HSIZE_BYTE, 32'h22, HTRANS_NONSEQ);
    tick();
    hwdata = 64'h0022_0000;
    drive_addr(1'b0, HSIZE_WORD, 32'h20, HTRANS_NONSEQ);
    tick();
    drive_idle();
    @(negedge hclk);
    $display("bytes read addr=00000020 rdata=%h ready=%b", rdata_a, rdy_a);
    n_cmp++; if (rdata_a !== 32'h0022_1100) begin n_bad++;
      $display("FAIL byte_merge: got %h expected 00221100", rdata_a); end
    xfer(1'b1, HSIZE_WORD, 32'h24, 64'h5555_5555, rd, waits, resp);
    xfer(1'b1, HSIZE_HALF, 32'h26, 64'hABCD_0000, rd, waits, resp);
    xfer(1'b0, HSIZE_WORD, 32'h24, 64'h0, rd, waits, resp);
    n_cmp++; if (rd[31:0] !== 32'hABCD_5555) begin n_bad++;
      $display("FAIL half_write: got %h expected abcd5555", rd[31:0]); end
  endtask

  task automatic test_error_pair();
    logic [63:0] rd;
    int          waits;
    logic [1:0]  resp;
    sel = 0;
    tick();
    drive_addr(1'b0, HSIZE_WORD, 32'h1000, HTRANS_NONSEQ);
    tick();
    drive_addr(1'b0, HSIZE_WORD, 32'h10, HTRANS_NONSEQ);
    @(negedge hclk);
    n_cmp++; if ({rdy_a, resp_a} !== {1'b0, HRESP_ERROR}) begin n_bad++;
      $display("FAIL err1_ready_resp: got %b expected 001", {rdy_a, resp_a}); end
    n_cmp++; if (rdata_a !== 32'h0) begin n_bad++;
      $display("FAIL err1_rdata: got %h expected 00000000", rdata_a); end
    tick();
    @(negedge hclk);
    n_cmp++; if ({rdy_a, resp_a} !== {1'b1, HRESP_ERROR}) begin n_bad++;
      $display("FAIL err2_ready_resp: got %b expected 101", {rdy_a, resp_a}); end
    tick();
    drive_idle();
    @(negedge hclk);
    $display("err pair then read addr=00000010 rdata=%h resp=%0d", rdata_a, resp_a);
    n_cmp++; if ({rdy_a, resp_a} !== {1'b1, HRESP_OKAY}) begin n_bad++;
      $display("FAIL after_err_ready_resp: got %b expected 100", {rdy_a, resp_a}); end
    n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_bad++;
      $display("FAIL after_err_data: got %h expected deadbeef", rdata_a); end
    xfer(1'b0, HSIZE_DWORD, 32'h30, 64'h0, rd, waits, resp);
    n_cmp++; if (resp !== HRESP_ERROR || waits != 1) begin n_bad++;
      $display("FAIL size_err: got resp=%0d waits=%0d expected resp=1 waits=1", resp, waits); end
    xfer(1'b1, HSIZE_WORD, 32'hFFC, 64'h600D_F00D, rd, waits, resp);
    xfer(1'b0, HSIZE_WORD, 32'hFFC, 64'h0, rd, waits, resp);
    n_cmp++; if (resp !== HRESP_OKAY || rd[31:0] !== 32'h600D_F00D) begin n_bad++;
      $display("FAIL last_word: got resp=%0d data=%h expected resp=0 data=600df00d", resp, rd[31:0]); end
  endtask

  task automatic test_unaligned();
    logic [63:0] rd;
    int          waits;
    logic [1:0]  resp;
    sel = 0;
    xfer(1'b1, HSIZE_WORD, 32'h0, 64'h1234_5678, rd, waits, resp);
    xfer(1'b1, HSIZE_WORD, 32'h2, 64'hAAAA_AAAA, rd, waits, resp);
    n_cmp++; if (resp !== HRESP_ERROR || waits != 1) begin n_bad++;
      $display("FAIL unaligned_err: got resp=%0d waits=%0d expected resp=1 waits=1", resp, waits); end
    xfer(1'b0, HSIZE_WORD, 32'h0, 64'h0, rd, waits, resp);
    n_cmp++; if (rd[31:0] !== 32'h1234_5678) begin n_bad++;
      $display("FAIL unaligned_untouched: got %h expected 12345678", rd[31:0]); end
    sel = 1;
    xfer(1'b1, HSIZE_WORD, 32'h2, 64'hCAFE_F00D, rd, waits, resp);
    n_cmp++; if (resp !== HRESP_OKAY || waits != 3) begin n_bad++;
      $display("FAIL masked_write: got resp=%0d waits=%0d expected resp=0 waits=3", resp, waits); end
    xfer(1'b0, HSIZE_WORD, 32'h0, 64'h0, rd, waits, resp);
    n_cmp++; if (rd[31:0] !== 32'hCAFE_F00D) begin n_bad++;
      $display("FAIL masked_word: got %h expected cafef00d", rd[31:0]); end
    xfer(1'b1, HSIZE_HALF, 32'h3, 64'hBEEF_0000, rd, waits, resp);
    xfer(1'b0, HSIZE_WORD, 32'h0, 64'h0, rd, waits, resp);
    n_cmp++; if (rd[31:0] !== 32'hBEEF_F00D) begin n_bad++;
      $display("FAIL masked_half: got %h expected beeff00d", rd[31:0]); end
  endtask

  task automatic test_wait_burst();
    logic [63:0] rd;
    int          waits;
    int          dcycles;
    logic [1:0]  resp;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h1111_0040;
    exp_w[1] = 32'h2222_0044;
    exp_w[2] = 32'h3333_0048;
    exp_w[3] = 32'h4444_004C;
    sel = 1;
    for (int k = 0; k < 4; k++) begin
      xfer(1'b1, HSIZE_WORD, 32'h40 + 32'(4 * k), {32'h0, exp_w[k]}, rd, waits, resp);
    end
    tick();
    hburst = HBURST_INCR4;
    drive_addr(1'b0, HSIZE_WORD, 32'h40, HTRANS_NONSEQ);
    dcycles = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) drive_addr(1'b0, HSIZE_WORD, 32'h40 + 32'(4 * (k + 1)), HTRANS_SEQ);
      else       drive_idle();
      waits = 0;
      dcycles++;
      @(negedge hclk);
      while (!rdy_b && waits < 20) begin
        n_cmp++; if (rdata_b !== 32'h0) begin n_bad++;
          $display("FAIL burst_wait_rdata[%0d]: got %h expected 00000000", k, rdata_b); end
        waits++;
        tick();
        dcycles++;
        @(negedge hclk);
      end
      $display("burst beat %0d addr=%h rdata=%h waits=%0d", k, 32'h40 + 32'(4 * k), rdata_b, waits);
      n_cmp++; if (waits != 3) begin n_bad++;
        $display("FAIL burst_waits[%0d]: got %0d expected 3", k, waits); end
      n_cmp++; if (rdata_b !== exp_w[k] || resp_b !== HRESP_OKAY) begin n_bad++;
        $display("FAIL burst_data[%0d]: got %h/%0d expected %h/0", k, rdata_b, resp_b, exp_w[k]); end
    end
    n_cmp++; if (dcycles != 16) begin n_bad++;
      $display("FAIL burst_cycles: got %0d expected 16", dcycles); end
    tick();
    hburst = HBURST_SINGLE;
  endtask

  task automatic test_wide_reset();
    logic [63:0] rd;
    int          waits;
    logic [1:0]  resp;
    sel = 2;
    xfer(1'b1, HSIZE_DWORD, 32'h8008, 64'h0123_4567_89AB_CDEF, rd, waits, resp);
    n_cmp++; if (resp !== HRESP_OKAY || waits != 2) begin n_bad++;
      $display("FAIL wide_write: got resp=%0d waits=%0d expected resp=0 waits=2", resp, waits); end
    tick();
    drive_addr(1'b1, HSIZE_DWORD, 32'h8008, HTRANS_NONSEQ);
    tick();
    hwdata = 64'hFFFF_FFFF_FFFF_FFFF;
    drive_idle();
    @(negedge hclk);
    n_cmp++; if (rdy_c !== 1'b0) begin n_bad++;
      $display("FAIL rst_wait1_ready: got %b expected 0", rdy_c); end
    tick();
    hreset = 1'b1;
    #1;
    $display("reset mid-write ready=%b resp=%0d rdata=%h", rdy_c, resp_c, rdata_c);
    n_cmp++; if ({rdy_c, resp_c} !== {1'b1, HRESP_OKAY} || rdata_c !== 64'h0) begin n_bad++;
      $display("FAIL rst_mid_outputs: got %b/%h expected 100/0", {rdy_c, resp_c}, rdata_c); end
    @(posedge hclk);
    #1 hreset = 1'b0;
    hwdata = '0;
    xfer(1'b0, HSIZE_DWORD, 32'h8008, 64'h0, rd, waits, resp);
    n_cmp++; if (rd !== 64'h0123_4567_89AB_CDEF) begin n_bad++;
      $display("FAIL rst_old_data: got %h expected 0123456789abcdef", rd); end
    xfer(1'b1, HSIZE_BYTE, 32'h800D, 64'h0000_5A00_0000_0000, rd, waits, resp);
    xfer(1'b0, HSIZE_DWORD, 32'h8008, 64'h0, rd, waits, resp);
    n_cmp++; if (rd !== 64'h0123_5A67_89AB_CDEF) begin n_bad++;
      $display("FAIL wide_byte_lane: got %h expected 01235a6789abcdef", rd); end
    xfer(1'b0, HSIZE_DWORD, 32'h7FF8, 64'h0, rd, waits, resp);
    n_cmp++; if (resp !== HRESP_ERROR) begin n_bad++;
      $display("FAIL below_base: got resp=%0d expected 1", resp); end
    xfer(1'b0, HSIZE_DWORD, 32'h8800, 64'h0, rd, waits, resp);
    n_cmp++; if (resp !== HRESP_ERROR) begin n_bad++;
      $display("FAIL above_top: got resp=%0d expected 1", resp); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_error_pair();
    test_unaligned();
    test_wait_burst();
    test_wide_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d compared, expected completion", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
